pwm_multi_gen: RTL and testbench
================================

Name: pwm_multi_gen

Overview:
- Parametrised multi-channel PWM generator with a per-channel duty cycle.
- Each channel has its own debounced increase/decrease buttons, saturating duty arithmetic, and a glitch-free shadow-duty update at the period boundary.
- Channel phases are optionally staggered across the period.
- Sits between board push-buttons and motor/LED drivers, replacing the fixed single-channel, 10-step generator.

Parameters:
- CHANNELS, 4, number of independent PWM channels.
- CNT_W, 8, width of the period counter and duty registers; requires PERIOD <= 2^CNT_W - 1.
- PERIOD, 100, PWM period in clk cycles; counter runs 0..PERIOD-1.
- STEP, 10, duty increment/decrement per accepted button press.
- INIT_DUTY, 50, reset duty for every channel; requires INIT_DUTY <= PERIOD.
- DEB_DIV, 4, debounce sample interval in clk cycles; must be >= 1.
- STAGGER, 1, 1 = channel i phase offset i*(PERIOD/CHANNELS); 0 = all channels in phase.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- inc_btn  input  CHANNELS  raw increase buttons, one bit per channel, asynchronous to clk.
- dec_btn  input  CHANNELS  raw decrease buttons, one bit per channel.
- pwm_out  output  CHANNELS  registered PWM outputs.
- duty_o  output  CHANNELS*CNT_W  active duty per channel; channel i occupies [i*CNT_W +: CNT_W].
- period_start  output  1  one-cycle pulse, registered, on the cycle the base counter equals 0.

Behaviour:
- Reset (asynchronous, active-high; clock clk):
  - cnt = 0, div = 0.
  - All synchroniser, sample and event flops = 0.
  - target_duty[i] = active_duty[i] = INIT_DUTY.
  - pwm_out = 0, period_start = 0.
  - Asserting reset mid-period aborts the period immediately; outputs go low asynchronously.
- Base counter:
  - cnt increments every cycle and wraps from PERIOD-1 to 0.
  - period_start <= (cnt == PERIOD-1), so it is high in the cycle the counter shows 0.
- Synchroniser: each button bit passes through 2 flops every cycle, giving sync2.
- Sample enable: div counts 0..DEB_DIV-1 and wraps; sample_en = (div == DEB_DIV-1).
- Debounce and edge detect, per button:
  - On a sample_en cycle: smp <= sync2, and evt <= sync2 & ~smp.
  - Otherwise evt <= 0.
  - evt is therefore a one-cycle pulse per accepted rising edge.
  - A held button generates exactly one event; releasing and re-pressing generates another.
- Target duty update, per channel, in the cycle evt is high:
  - inc only: target = min(target+STEP, PERIOD), computed CNT_W+1 bits wide so there is no wrap.
  - dec only: target = (target < STEP) ? 0 : target-STEP.
  - inc and dec in the same cycle: no change.
- Shadow load: active_duty[i] <= target_duty[i] only in the cycle cnt == PERIOD-1. A change never truncates or extends the current period.
- Phase:
  - ph[i] = (cnt + off[i]) mod PERIOD, where off[i] = STAGGER ? i*(PERIOD/CHANNELS) : 0.
  - Implement the modulo as a single conditional subtract; no divider.
- Output: pwm_out[i] <= (ph[i] < active_duty[i]), a 1-cycle registered latency.
  - duty 0 gives a constant low output.
  - duty PERIOD gives a constant high output.
- Latency from button edge to pwm change:
  - 2 sync cycles, plus up to DEB_DIV to the sample, plus 1 evt cycle, plus 1 update cycle.
  - Then wait to the next period boundary, plus 1 output cycle.
- duty_o reflects active_duty, not target_duty.

Test Plan (CHANNELS=2, PERIOD=10, STEP=1, INIT_DUTY=5, DEB_DIV=2, CNT_W=4 unless stated):
- Reset release, no buttons:
  - pwm_out[0] high exactly 5 of every 10 cycles.
  - pwm_out[1] is the same waveform shifted by 5 cycles.
  - period_start every 10 cycles; duty_o = {5,5}.
- One clean press on inc_btn[0], held 40 cycles:
  - Exactly one increment; duty_o[0] becomes 6 at the next boundary.
  - High time goes to 6/10 with no partial period.
- Drive duty to limits with 12 presses of inc, then 12 presses of dec:
  - duty saturates at 10 (constant high), then at 0 (constant low).
  - No wrap at any point.
- Simultaneous inc_btn[1] and dec_btn[1] rising in the same cycle → duty_o[1] stays 5.
- Press during mid-period (cnt=3) → the current period keeps the old duty; the new duty applies from the next cnt=0.
- Assert reset at cnt=7 with duty 8:
  - pwm_out goes to 0 immediately.
  - After release, duty_o = {5,5} and the period restarts at cnt=0.
- STAGGER=0 variant → both channels produce identical waveforms.

Source files
------------

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: a shared period counter and debounce tick drive
// per-channel button debounce, saturating duty arithmetic and a boundary-loaded duty.

module pwm_chan #(
    parameter int CNT_W     = 8,
    parameter int PERIOD    = 100,
    parameter int STEP      = 10,
    parameter int INIT_DUTY = 50,
    parameter int OFF       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_raw,
    input  logic             dec_raw,
    input  logic             sample_en,
    input  logic [CNT_W-1:0] cnt,
    input  logic             last,
    output logic             pwm,
    output logic [CNT_W-1:0] duty
);
    localparam logic [CNT_W:0]   PER_X  = (CNT_W+1)'(PERIOD);
    localparam logic [CNT_W:0]   STEP_X = (CNT_W+1)'(STEP);
    localparam logic [CNT_W:0]   OFF_X  = (CNT_W+1)'(OFF);
    localparam logic [CNT_W-1:0] INIT_D = CNT_W'(INIT_DUTY);

    logic [1:0]       inc_sync, dec_sync;
    logic             inc_smp, dec_smp, inc_evt, dec_evt;
    logic [CNT_W-1:0] target, active, target_nxt, ph;
    logic [CNT_W:0]   inc_sum, ph_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc_sync <= '0;
            dec_sync <= '0;
            inc_smp  <= 1'b0;
            dec_smp  <= 1'b0;
            inc_evt  <= 1'b0;
            dec_evt  <= 1'b0;
        end else begin
            inc_sync <= {inc_sync[0], inc_raw};
            dec_sync <= {dec_sync[0], dec_raw};
            if (sample_en) begin
                inc_smp <= inc_sync[1];
                dec_smp <= dec_sync[1];
                inc_evt <= inc_sync[1] & ~inc_smp;
                dec_evt <= dec_sync[1] & ~dec_smp;
            end else begin
                inc_evt <= 1'b0;
                dec_evt <= 1'b0;
            end
        end
    end

    // Sum kept one bit wider so a clamp at PERIOD can never wrap.
    always_comb begin
        inc_sum    = {1'b0, target} + STEP_X;
        target_nxt = target;
        if (inc_evt && !dec_evt)
            target_nxt = (inc_sum > PER_X) ? PER_X[CNT_W-1:0] : inc_sum[CNT_W-1:0];
        else if (dec_evt && !inc_evt)
            target_nxt = ({1'b0, target} < STEP_X) ? '0 : target - STEP_X[CNT_W-1:0];
    end

    // OFF < PERIOD, so one conditional subtract gives the modulo.
    always_comb begin
        ph_sum = {1'b0, cnt} + OFF_X;
        ph     = (ph_sum >= PER_X) ? CNT_W'(ph_sum - PER_X) : ph_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target <= INIT_D;
            active <= INIT_D;
            pwm    <= 1'b0;
        end else begin
            target <= target_nxt;
            if (last)
                active <= target;
            pwm <= (ph < active);
        end
    end

    assign duty = active;
endmodule

module pwm_multi_gen #(
    parameter int CHANNELS  = 4,
    parameter int CNT_W     = 8,
    parameter int PERIOD    = 100,
    parameter int STEP      = 10,
    parameter int INIT_DUTY = 50,
    parameter int DEB_DIV   = 4,
    parameter int STAGGER   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       inc_btn,
    input  logic [CHANNELS-1:0]       dec_btn,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic [CHANNELS*CNT_W-1:0] duty_o,
    output logic                      period_start
);
    localparam int               DIV_W    = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DEB_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0]                cnt;
    logic [DIV_W-1:0]                div;
    logic                            last, sample_en;
    logic [CHANNELS-1:0][CNT_W-1:0]  duty_a;

    assign last      = (cnt == CNT_LAST);
    assign sample_en = (div == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            div          <= '0;
            period_start <= 1'b0;
        end else begin
            cnt          <= last ? '0 : cnt + 1'b1;
            div          <= sample_en ? '0 : div + 1'b1;
            period_start <= last;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_chan #(
            .CNT_W    (CNT_W),
            .PERIOD   (PERIOD),
            .STEP     (STEP),
            .INIT_DUTY(INIT_DUTY),
            .OFF      (STAGGER != 0 ? i * (PERIOD / CHANNELS) : 0)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .inc_raw  (inc_btn[i]),
            .dec_raw  (dec_btn[i]),
            .sample_en(sample_en),
            .cnt      (cnt),
            .last     (last),
            .pwm      (pwm_out[i]),
            .duty     (duty_a[i])
        );
    end

    assign duty_o = duty_a;
endmodule

// File: tb/tb_pwm_multi_gen.sv
// Randomised bench for pwm_multi_gen: an ideal-waveform model (position in period
// versus duty) checked every cycle, plus per-scenario checks.

module tb_pwm_multi_gen;
    localparam int CH = 2, W = 4, P = 10, STEP = 1, INIT = 5, DD = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [CH-1:0]   inc_btn = '0, dec_btn = '0;
    logic [CH-1:0]   pwm_out, pwm0;
    logic [CH*W-1:0] duty_o, duty0;
    logic            ps, ps0;

    int checks = 0, errors = 0;
    bit mon_en = 1'b0;

    int              mcnt;
    int              mactive[CH];
    int              mtarget[CH];
    logic [CH-1:0]   exp_pwm, exp_pwm0;
    logic            exp_ps;
    logic [CH*W-1:0] exp_duty;

    pwm_multi_gen #(.CHANNELS(CH), .CNT_W(W), .PERIOD(P), .STEP(STEP), .INIT_DUTY(INIT),
                    .DEB_DIV(DD), .STAGGER(1)) dut (
        .clk(clk), .reset(reset), .inc_btn(inc_btn), .dec_btn(dec_btn),
        .pwm_out(pwm_out), .duty_o(duty_o), .period_start(ps));

    pwm_multi_gen #(.CHANNELS(CH), .CNT_W(W), .PERIOD(P), .STEP(STEP), .INIT_DUTY(INIT),
                    .DEB_DIV(DD), .STAGGER(0)) dut0 (
        .clk(clk), .reset(reset), .inc_btn(inc_btn), .dec_btn(dec_btn),
        .pwm_out(pwm0), .duty_o(duty0), .period_start(ps0));

    always #5 clk = ~clk;

    // Ideal behaviour: output high while the channel's position in the period is below
    // the duty in force for that period; new duty takes effect only at a boundary.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mcnt     <= 0;
            exp_pwm  <= '0;
            exp_pwm0 <= '0;
            exp_ps   <= 1'b0;
            for (int i = 0; i < CH; i++) mactive[i] <= INIT;
        end else begin
            for (int i = 0; i < CH; i++) begin
                exp_pwm[i]  <= (((mcnt + i * (P / CH)) % P) < mactive[i]);
                exp_pwm0[i] <= (mcnt < mactive[i]);
                if (mcnt == P - 1) mactive[i] <= mtarget[i];
            end
            exp_ps <= (mcnt == P - 1);
            mcnt   <= (mcnt + 1) % P;
        end
    end

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            exp_duty = {mactive[1][W-1:0], mactive[0][W-1:0]};
            checks += 6;
            if (pwm_out !== exp_pwm) begin
                errors++; $display("FAIL cyc_pwm t=%0t got %b want %b", $time, pwm_out, exp_pwm);
            end
            if (ps !== exp_ps) begin
                errors++; $display("FAIL cyc_period_start t=%0t got %b want %b", $time, ps, exp_ps);
            end
            if (duty_o !== exp_duty) begin
                errors++; $display("FAIL cyc_duty t=%0t got %h want %h", $time, duty_o, exp_duty);
            end
            if (pwm0 !== exp_pwm0) begin
                errors++; $display("FAIL cyc_pwm_nostagger t=%0t got %b want %b", $time, pwm0, exp_pwm0);
            end
            if (ps0 !== exp_ps) begin
                errors++; $display("FAIL cyc_ps_nostagger t=%0t got %b want %b", $time, ps0, exp_ps);
            end
            if (duty0 !== exp_duty) begin
                errors++; $display("FAIL cyc_duty_nostagger t=%0t got %h want %h", $time, duty0, exp_duty);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic wait_cnt(input int c);
        int n = 0;
        while (mcnt != c && n < 4 * P) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Pressing early in the period guarantees the debounced event lands before the boundary.
    task automatic press(input int ch, input bit up, input bit dn);
        int hold;
        wait_cnt(int'($urandom_range(0, 4)));
        hold = int'($urandom_range(6, 15));
        inc_btn[ch] = up;
        dec_btn[ch] = dn;
        if (up && !dn)      mtarget[ch] = (mtarget[ch] + STEP > P) ? P : mtarget[ch] + STEP;
        else if (dn && !up) mtarget[ch] = (mtarget[ch] < STEP) ? 0 : mtarget[ch] - STEP;
        repeat (hold) @(negedge clk);
        inc_btn[ch] = 1'b0;
        dec_btn[ch] = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic settle();
        repeat (2 * P) @(negedge clk);
    endtask

    task automatic test_reset();
        int hi0, hi1, nps;
        logic [P-1:0] w0, w1;
        for (int i = 0; i < CH; i++) mtarget[i] = INIT;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks += 3;
        if (pwm_out !== 2'b00) begin errors++; $display("FAIL rst_pwm got %b want 00", pwm_out); end
        if (ps !== 1'b0)       begin errors++; $display("FAIL rst_ps got %b want 0", ps); end
        if (duty_o !== 8'h55)  begin errors++; $display("FAIL rst_duty got %h want 55", duty_o); end
        #2 reset = 1'b0;
        mon_en = 1'b1;
        nps = 0;
        repeat (3 * P) begin @(negedge clk); nps += int'(ps); end
        checks++;
        if (nps != 3) begin errors++; $display("FAIL idle_period_starts got %0d want 3", nps); end
        wait_cnt(1);
        hi0 = 0; hi1 = 0;
        for (int j = 0; j < P; j++) begin
            w0[j] = pwm_out[0]; w1[j] = pwm_out[1];
            hi0 += int'(pwm_out[0]); hi1 += int'(pwm_out[1]);
            @(negedge clk);
        end
        checks += 2;
        if (hi0 != INIT) begin errors++; $display("FAIL idle_high_ch0 got %0d want %0d", hi0, INIT); end
        if (hi1 != INIT) begin errors++; $display("FAIL idle_high_ch1 got %0d want %0d", hi1, INIT); end
        for (int j = 0; j < P; j++) begin
            checks++;
            if (w1[j] !== w0[(j + P / CH) % P]) begin
                errors++; $display("FAIL idle_shift j=%0d got %b want %b", j, w1[j], w0[(j + P / CH) % P]);
            end
        end
    endtask

    task automatic test_single_press();
        int hi;
        wait_cnt(1);
        inc_btn[0] = 1'b1;
        mtarget[0] = INIT + STEP;
        repeat (40) @(negedge clk);
        inc_btn[0] = 1'b0;
        repeat (6) @(negedge clk);
        settle();
        checks++;
        if (int'(duty_o[3:0]) != 6) begin errors++; $display("FAIL single_duty got %0d want 6", duty_o[3:0]); end
        wait_cnt(1);
        hi = 0;
        repeat (P) begin hi += int'(pwm_out[0]); @(negedge clk); end
        checks++;
        if (hi != 6) begin errors++; $display("FAIL single_high got %0d want 6", hi); end
    endtask

    task automatic test_limits();
        int hi;
        for (int k = 0; k < 12; k++) press(0, 1'b1, 1'b0);
        settle();
        wait_cnt(1);
        hi = 0;
        repeat (P) begin hi += int'(pwm_out[0]); @(negedge clk); end
        checks += 2;
        if (int'(duty_o[3:0]) != P) begin errors++; $display("FAIL max_duty got %0d want %0d", duty_o[3:0], P); end
        if (hi != P) begin errors++; $display("FAIL max_high got %0d want %0d", hi, P); end
        for (int k = 0; k < 12; k++) press(0, 1'b0, 1'b1);
        settle();
        wait_cnt(1);
        hi = 0;
        repeat (P) begin hi += int'(pwm_out[0]); @(negedge clk); end
        checks += 2;
        if (int'(duty_o[3:0]) != 0) begin errors++; $display("FAIL min_duty got %0d want 0", duty_o[3:0]); end
        if (hi != 0) begin errors++; $display("FAIL min_high got %0d want 0", hi); end
    endtask

    task automatic test_simultaneous();
        press(1, 1'b1, 1'b1);
        settle();
        checks++;
        if (int'(duty_o[7:4]) != INIT) begin errors++; $display("FAIL simul_duty got %0d want %0d", duty_o[7:4], INIT); end
    endtask

    task automatic test_mid_period();
        wait_cnt(3);
        inc_btn[1] = 1'b1;
        mtarget[1] = INIT + STEP;
        wait_cnt(9);
        checks++;
        if (int'(duty_o[7:4]) != INIT) begin errors++; $display("FAIL mid_old_duty got %0d want %0d", duty_o[7:4], INIT); end
        @(negedge clk);
        checks++;
        if (int'(duty_o[7:4]) != INIT + STEP) begin
            errors++; $display("FAIL mid_new_duty got %0d want %0d", duty_o[7:4], INIT + STEP);
        end
        repeat (5) @(negedge clk);
        inc_btn[1] = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_random();
        for (int k = 0; k < 16; k++) begin
            int ch;
            bit up, dn;
            ch = int'($urandom_range(0, CH - 1));
            up = 1'($urandom_range(0, 1));
            dn = up ? 1'($urandom_range(0, 3) == 0) : 1'b1;
            press(ch, up, dn);
        end
        settle();
        for (int i = 0; i < CH; i++) begin
            checks++;
            if (int'(duty_o[i*W +: W]) != mtarget[i]) begin
                errors++; $display("FAIL rand_duty ch%0d got %0d want %0d", i, duty_o[i*W +: W], mtarget[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        while (mtarget[0] != 8 && n < 20) begin
            press(0, mtarget[0] < 8, mtarget[0] > 8);
            n++;
        end
        settle();
        wait_cnt(7);
        checks++;
        if (pwm_out[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_pwm got %b want 1", pwm_out[0]); end
        #2 reset = 1'b1;
        for (int i = 0; i < CH; i++) mtarget[i] = INIT;
        #1;
        checks += 3;
        if (pwm_out !== 2'b00) begin errors++; $display("FAIL async_rst_pwm got %b want 00", pwm_out); end
        if (pwm0 !== 2'b00)    begin errors++; $display("FAIL async_rst_pwm0 got %b want 00", pwm0); end
        if (duty_o !== 8'h55)  begin errors++; $display("FAIL async_rst_duty got %h want 55", duty_o); end
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        n = 0;
        while (!ps && n < 3 * P) begin @(negedge clk); n++; end
        checks++;
        if (n != P) begin errors++; $display("FAIL restart_period got %0d want %0d", n, P); end
    endtask

    task automatic test_no_stagger();
        int hi;
        wait_cnt(1);
        hi = 0;
        repeat (P) begin
            checks++;
            if (pwm0[1] !== pwm0[0]) begin errors++; $display("FAIL nostagger_match got %b want %b", pwm0[1], pwm0[0]); end
            hi += int'(pwm0[0]);
            @(negedge clk);
        end
        checks++;
        if (hi != INIT) begin errors++; $display("FAIL nostagger_high got %0d want %0d", hi, INIT); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_limits();
        test_simultaneous();
        test_mid_period();
        test_random();
        test_reset_mid();
        test_no_stagger();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
